// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronise, debounce and edge-detect two sensors, then arbitrate into clean pulses.
// Define COIN_COUNT_EN to add the saturating coin_total counter and its port.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4
`ifdef COIN_COUNT_EN
  , parameter int QUARTER_CENTS = 25
  , parameter int DOLLAR_CENTS  = 100
  , parameter int TOTAL_W       = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic quarter_raw,
  input  logic dollar_raw,
  input  logic accept_en,
  output logic Quarter,
  output logic Doller,
  output logic reject
`ifdef COIN_COUNT_EN
  , output logic [TOTAL_W-1:0] coin_total
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EMIT_D = 2'd1;
  localparam logic [1:0] S_EMIT_Q = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  // Channel index 0 = quarter, 1 = dollar.
  logic [1:0] w_raw;
  logic [1:0] w_event;
  logic [1:0] w_accept;
  logic [1:0] w_refuse;
  logic [1:0] w_clr;
  logic [1:0] r_pend;
  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_quarter;
  logic       r_doller;
  logic       r_reject;

  assign w_raw = {dollar_raw, quarter_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic          r_sync1;
      logic          r_sync2;
      logic          r_stable;
      logic          r_stable_d;
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sync1    <= 1'b0;
          r_sync2    <= 1'b0;
          r_stable   <= 1'b0;
          r_stable_d <= 1'b0;
          r_cnt      <= '0;
        end else begin
          r_sync1    <= w_raw[gi];
          r_sync2    <= r_sync1;
          r_stable_d <= r_stable;
          if (r_sync2 == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_event[gi]  = r_stable & ~r_stable_d;
      assign w_accept[gi] = w_event[gi] & accept_en & ~r_pend[gi];
      assign w_refuse[gi] = w_event[gi] & (~accept_en | r_pend[gi]);
    end
  endgenerate

  // GAP re-arbitrates like IDLE so a queued coin follows after exactly one low cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_GAP: begin
        if (r_pend[1])      w_state_next = S_EMIT_D;
        else if (r_pend[0]) w_state_next = S_EMIT_Q;
        else                w_state_next = S_IDLE;
      end
      S_EMIT_D: w_state_next = S_GAP;
      S_EMIT_Q: w_state_next = S_GAP;
      default:  w_state_next = S_IDLE;
    endcase
  end

  assign w_clr = {w_state_next == S_EMIT_D, w_state_next == S_EMIT_Q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pend    <= 2'b00;
      r_quarter <= 1'b0;
      r_doller  <= 1'b0;
      r_reject  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pend    <= (r_pend & ~w_clr) | w_accept;
      r_doller  <= (w_state_next == S_EMIT_D);
      r_quarter <= (w_state_next == S_EMIT_Q);
      r_reject  <= |w_refuse;
    end
  end

  assign Quarter = r_quarter;
  assign Doller  = r_doller;
  assign reject  = r_reject;

`ifdef COIN_COUNT_EN
  localparam logic [TOTAL_W:0] TOTAL_MAX = {1'b0, {TOTAL_W{1'b1}}};

  logic [TOTAL_W-1:0] r_total;
  logic [TOTAL_W:0]   w_sum;

  assign w_sum = {1'b0, r_total}
               + (r_doller  ? (TOTAL_W+1)'(DOLLAR_CENTS)  : '0)
               + (r_quarter ? (TOTAL_W+1)'(QUARTER_CENTS) : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total <= '0;
    end else if (w_sum > TOTAL_MAX) begin
      r_total <= '1;
    end else begin
      r_total <= w_sum[TOTAL_W-1:0];
    end
  end

  assign coin_total = r_total;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with DEBOUNCE_CYCLES=4; edge k = k-th rising edge after the raw change.
module tb_coin_acceptor;

  logic clk = 1'b0;
  logic rst;
  logic quarter_raw;
  logic dollar_raw;
  logic accept_en;
  logic Quarter;
  logic Doller;
  logic reject;
`ifdef COIN_COUNT_EN
  logic [15:0] coin_total;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  coin_acceptor #(.DEBOUNCE_CYCLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .quarter_raw (quarter_raw),
    .dollar_raw  (dollar_raw),
    .accept_en   (accept_en),
    .Quarter     (Quarter),
    .Doller      (Doller),
    .reject      (reject)
`ifdef COIN_COUNT_EN
    , .coin_total (coin_total)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, counting cycles with any output pulse high.
  task automatic watch(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (Quarter || Doller || reject) pulses++;
    end
  endtask

  task automatic test_reset();
    int hits;
    rst = 1'b1;
    quarter_raw = 1'b0;
    dollar_raw = 1'b0;
    accept_en = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      quarter_raw = i[0];
      dollar_raw  = i[1];
      step();
      if (Quarter || Doller || reject) hits++;
    end
    chk_cnt++;
    if (hits !== 0) $display("FAIL reset_held: pulse cycles %0d, required 0", hits);
    else pass_cnt++;
    @(negedge clk);
    quarter_raw = 1'b0;
    dollar_raw = 1'b0;
    rst = 1'b0;
    watch(15, hits);
    chk_cnt++;
    if (hits !== 0) $display("FAIL reset_release: pulse cycles %0d, required 0", hits);
    else pass_cnt++;
`ifdef COIN_COUNT_EN
    chk_cnt++;
    if (coin_total !== 16'd0) $display("FAIL reset_total: got %0d, required 0", coin_total);
    else pass_cnt++;
`endif
    $display("test_reset done");
  endtask

  task automatic test_single_quarter();
    int hits;
    @(negedge clk);
    quarter_raw = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step();
      chk_cnt++;
      if ({Quarter, Doller, reject} !== {(k == 8), 1'b0, 1'b0})
        $display("FAIL quarter_latency edge %0d: Q/D/rej got %b%b%b, required %b00",
                 k, Quarter, Doller, reject, (k == 8));
      else pass_cnt++;
`ifdef COIN_COUNT_EN
      if (k == 9) begin
        chk_cnt++;
        if (coin_total !== 16'd25) $display("FAIL quarter_total: got %0d, required 25", coin_total);
        else pass_cnt++;
      end
`endif
    end
    @(negedge clk);
    quarter_raw = 1'b0;
    watch(20, hits);
    chk_cnt++;
    if (hits !== 0) $display("FAIL quarter_release: pulse cycles %0d, required 0", hits);
    else pass_cnt++;
    $display("test_single_quarter done");
  endtask

  task automatic test_simultaneous();
    int hits;
    @(negedge clk);
    quarter_raw = 1'b1;
    dollar_raw = 1'b1;
    for (int k = 0; k <= 13; k++) begin
      step();
      chk_cnt++;
      if ({Doller, Quarter} !== {(k == 8), (k == 10)})
        $display("FAIL simul_order edge %0d: D/Q got %b%b, required %b%b",
                 k, Doller, Quarter, (k == 8), (k == 10));
      else pass_cnt++;
`ifdef COIN_COUNT_EN
      if (k == 11) begin
        chk_cnt++;
        if (coin_total !== 16'd150) $display("FAIL simul_total: got %0d, required 150", coin_total);
        else pass_cnt++;
      end
`endif
    end
    @(negedge clk);
    quarter_raw = 1'b0;
    dollar_raw = 1'b0;
    watch(20, hits);
    chk_cnt++;
    if (hits !== 0) $display("FAIL simul_release: pulse cycles %0d, required 0", hits);
    else pass_cnt++;
    $display("test_simultaneous done");
  endtask

  task automatic test_bounce();
    // Per-cycle raw pattern: bounces of 1..3 high cycles, then a 10-cycle hold, then release.
    logic pattern [0:36];
    int nq;
    int nother;
    for (int i = 0; i <= 36; i++) pattern[i] = 1'b0;
    pattern[0] = 1'b1;
    pattern[3] = 1'b1; pattern[4] = 1'b1;
    pattern[7] = 1'b1; pattern[8] = 1'b1; pattern[9] = 1'b1;
    for (int i = 12; i < 22; i++) pattern[i] = 1'b1;
    nq = 0;
    nother = 0;
    for (int i = 0; i <= 36; i++) begin
      @(negedge clk);
      quarter_raw = pattern[i];
      step();
      if (Quarter) nq++;
      if (Doller || reject) nother++;
    end
    chk_cnt++;
    if (nq !== 1) $display("FAIL bounce_quarter_count: got %0d, required 1", nq);
    else pass_cnt++;
    chk_cnt++;
    if (nother !== 0) $display("FAIL bounce_other_pulses: got %0d, required 0", nother);
    else pass_cnt++;
`ifdef COIN_COUNT_EN
    chk_cnt++;
    if (coin_total !== 16'd175) $display("FAIL bounce_total: got %0d, required 175", coin_total);
    else pass_cnt++;
`endif
    $display("test_bounce done");
  endtask

  task automatic test_reject();
    int hits;
    @(negedge clk);
    accept_en = 1'b0;
    dollar_raw = 1'b1;
    for (int k = 0; k <= 12; k++) begin
      step();
      chk_cnt++;
      if ({reject, Doller, Quarter} !== {(k == 7), 1'b0, 1'b0})
        $display("FAIL reject_pulse edge %0d: rej/D/Q got %b%b%b, required %b00",
                 k, reject, Doller, Quarter, (k == 7));
      else pass_cnt++;
    end
    @(negedge clk);
    dollar_raw = 1'b0;
    watch(20, hits);
    accept_en = 1'b1;
    chk_cnt++;
    if (hits !== 0) $display("FAIL reject_release: pulse cycles %0d, required 0", hits);
    else pass_cnt++;
`ifdef COIN_COUNT_EN
    chk_cnt++;
    if (coin_total !== 16'd175) $display("FAIL reject_total: got %0d, required 175", coin_total);
    else pass_cnt++;
`endif
    $display("test_reject done");
  endtask

  task automatic test_reset_midflight();
    int hits;
    int early;
    early = 0;
    @(negedge clk);
    dollar_raw = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      step();
      if (Quarter || Doller || reject) early++;
    end
    // Coin captured as pending; reset lands before the IDLE->EMIT edge.
    rst = 1'b1;
    dollar_raw = 1'b0;
    #1;
`ifdef COIN_COUNT_EN
    chk_cnt++;
    if (coin_total !== 16'd0) $display("FAIL midflight_total: got %0d, required 0", coin_total);
    else pass_cnt++;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    watch(25, hits);
    chk_cnt++;
    if (early + hits !== 0) $display("FAIL midflight_no_pulse: pulse cycles %0d, required 0", early + hits);
    else pass_cnt++;
    $display("test_reset_midflight done");
  endtask

  task automatic test_async_reset();
    int hits;
    @(negedge clk);
    dollar_raw = 1'b1;
    for (int k = 0; k <= 8; k++) step();
    chk_cnt++;
    if (Doller !== 1'b1) $display("FAIL async_pre_doller: got %b, required 1", Doller);
    else pass_cnt++;
    #1;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (Doller !== 1'b0) $display("FAIL async_clear_doller: got %b, required 0", Doller);
    else pass_cnt++;
    dollar_raw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    watch(25, hits);
    chk_cnt++;
    if (hits !== 0) $display("FAIL async_after_release: pulse cycles %0d, required 0", hits);
    else pass_cnt++;
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_single_quarter();
    test_simultaneous();
    test_bounce();
    test_reject();
    test_reset_midflight();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
